// File: rtl/dfd_apb_cmd_master.sv
// APB4 requester: queues register commands, runs one APB transfer per command
// with a bounded access phase, and returns one in-order response per command.
module dfd_apb_cmd_master #(
    parameter int ADDR_W         = 23,
    parameter int DATA_W         = 32,
    parameter int CMD_DEPTH      = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_slverr,
    output logic                rsp_timeout,

    output logic [ADDR_W-1:0]   paddr,
    output logic                pwrite,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    output logic                psel,
    output logic                penable,
    input  logic                pready,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pslverr,

    output logic                busy
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W  = $clog2(CMD_DEPTH + 1);
    localparam int TO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : TO_W'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t            state;
    cmd_t              mem [CMD_DEPTH];
    cmd_t              head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [TO_W-1:0]   to_cnt;
    logic              push;
    logic              pop;

    assign cmd_ready = (count != CNT_W'(CMD_DEPTH));
    assign busy      = (count != '0) || (state != IDLE);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == SETUP);
    assign head      = mem[rd_ptr];

    // NOTE: the command storage has no reset; count and the pointers decide
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{write: cmd_write, addr: cmd_addr,
                             wdata: cmd_wdata, strb: cmd_strb};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // NOTE: every register here uses <= so all decisions see pre-edge values,
    // regardless of statement order inside the block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            pstrb       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
            to_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        paddr  <= head.addr;
                        pwrite <= head.write;
                        pwdata <= head.write ? head.wdata : '0;
                        pstrb  <= head.write ? head.strb  : '0;
                        psel   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    to_cnt  <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_slverr  <= pslverr;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else if ((TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST)) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_slverr  <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                RESP: begin
                    // Response fields stay put until the consumer takes them.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dfd_apb_cmd_master.sv
// Directed bench for dfd_apb_cmd_master: APB slave model, in-order response
// scoreboard, and hand-computed latency/data expectations.
module tb_dfd_apb_cmd_master;
    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int TO     = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic [STRB_W-1:0] cmd_strb = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_slverr;
    logic              rsp_timeout;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic              psel;
    logic              penable;
    logic              pready = 1'b0;
    logic [DATA_W-1:0] prdata = '0;
    logic              pslverr = 1'b0;
    logic              busy;

    always #5 clk = ~clk;

    dfd_apb_cmd_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_DEPTH(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .psel(psel), .penable(penable), .pready(pready), .prdata(prdata),
        .pslverr(pslverr), .busy(busy)
    );

    // Each accepted command carries the slave behaviour it will meet.
    typedef struct {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
        int                wait_n;
        logic              err;
        logic [DATA_W-1:0] rdata;
        logic              hang;
    } txn_t;

    txn_t txn [64];
    int   n_pushed = 0;
    int   apb_idx  = 0;
    int   rsp_idx  = 0;
    int   vectors  = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic timed_out(input txn_t t);
        return t.hang || (t.wait_n + 1 > TO);
    endfunction

    function automatic int exp_cycles(input txn_t t);
        return timed_out(t) ? TO : t.wait_n + 1;
    endfunction

    // {timeout, slverr, rdata}
    function automatic logic [33:0] exp_rsp(input txn_t t);
        if (timed_out(t)) return {1'b1, 1'b1, 32'h0};
        return {1'b0, t.err, t.write ? 32'h0 : t.rdata};
    endfunction

    // APB slave: pready after wait_n stalled ACCESS cycles unless hanging.
    int   sl_k = 0;
    txn_t sl_t;
    always @(posedge clk) begin
        #1;
        if (!reset && psel && penable && apb_idx < n_pushed) begin
            sl_k++;
            sl_t = txn[apb_idx];
            if (!sl_t.hang && sl_k > sl_t.wait_n) begin
                pready  = 1'b1;
                prdata  = sl_t.rdata;
                pslverr = sl_t.err;
            end else begin
                pready  = 1'b0;
                prdata  = 32'h1234_5678;
                pslverr = 1'b1;
            end
        end else begin
            sl_k    = 0;
            pready  = 1'b0;
            prdata  = 32'h1234_5678;
            pslverr = 1'b1;
        end
    end

    // Scoreboard: APB request fields, access length, and response contents.
    int   acc_cnt = 0;
    logic in_txn  = 1'b0;
    txn_t cmp_t;
    always @(negedge clk) begin
        if (reset) begin
            acc_cnt = 0;
            in_txn  = 1'b0;
        end else begin
            if (psel) begin
                if (apb_idx >= n_pushed) begin
                    check("psel_without_cmd", apb_idx, n_pushed - 1);
                end else begin
                    cmp_t = txn[apb_idx];
                    check("paddr", paddr, cmp_t.addr);
                    check("pwrite", pwrite, cmp_t.write);
                    check("pwdata", pwdata, cmp_t.write ? cmp_t.wdata : 32'h0);
                    check("pstrb", pstrb, cmp_t.write ? cmp_t.strb : 4'h0);
                    if (penable) acc_cnt++;
                    else check("setup_after_access", acc_cnt, 0);
                    in_txn = 1'b1;
                end
            end else if (in_txn) begin
                check("access_cycles", acc_cnt, exp_cycles(txn[apb_idx]));
                apb_idx++;
                acc_cnt = 0;
                in_txn  = 1'b0;
            end
            if (penable) check("penable_needs_psel", psel, 1'b1);
            if (rsp_valid) begin
                if (rsp_idx >= apb_idx) begin
                    check("rsp_without_txn", rsp_idx, apb_idx - 1);
                end else begin
                    check("rsp_fields", {rsp_timeout, rsp_slverr, rsp_rdata}, exp_rsp(txn[rsp_idx]));
                    if (rsp_ready) rsp_idx++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [STRB_W-1:0] s, input int wn, input logic e,
                        input logic [DATA_W-1:0] rd, input logic h);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("cmd_accept_bound", cmd_ready, 1'b1);
        end else begin
            @(posedge clk);
            txn[n_pushed] = '{w, a, d, s, wn, e, rd, h};
            n_pushed++;
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input int exp_n);
        int n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        check(name, n, exp_n);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((rsp_idx != n_pushed || busy) && n < 400) begin
            tick();
            n++;
        end
        check(name, {rsp_idx != n_pushed, busy}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    int base;
    initial begin
        repeat (2) @(negedge clk);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_pstrb", pstrb, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_slverr", rsp_slverr, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        tick();
        reset = 1'b0;
        tick();

        // Write then read back the same register, zero wait states.
        push(1'b1, 23'h000248, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'hCAFE_F00D, 1'b0);
        check("wr_n_psel", psel, 0);
        tick();
        check("wr_n1_psel", psel, 1);
        check("wr_n1_penable", penable, 0);
        check("wr_n1_pwdata", pwdata, 32'hDEADBEEF);
        tick();
        check("wr_n2_penable", penable, 1);
        tick();
        check("wr_n3_rsp_valid", rsp_valid, 1);
        check("wr_rsp_rdata", rsp_rdata, 32'h0);
        check("wr_rsp_slverr", rsp_slverr, 0);
        wait_idle("wr_drain");

        push(1'b0, 23'h000248, 32'h5555_AAAA, 4'hF, 0, 1'b0, 32'hDEADBEEF, 1'b0);
        tick();
        check("rd_psel", psel, 1);
        check("rd_pstrb", pstrb, 4'h0);
        check("rd_pwdata", pwdata, 32'h0);
        tick();
        tick();
        check("rd_n3_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        wait_idle("rd_drain");

        // Five wait states, error at completion.
        push(1'b0, 23'h00010C, 32'h0, 4'h0, 5, 1'b1, 32'h0000_00A5, 1'b0);
        wait_rsp("wait5_latency", 8);
        check("wait5_slverr", rsp_slverr, 1);
        check("wait5_timeout", rsp_timeout, 0);
        check("wait5_rdata", rsp_rdata, 32'hA5);
        wait_idle("wait5_drain");

        // Slave never answers; the queued write behind it proceeds normally.
        push(1'b0, 23'h000200, 32'h0, 4'h0, 0, 1'b0, 32'h0BAD_CAFE, 1'b1);
        push(1'b1, 23'h000204, 32'h1122_3344, 4'h3, 1, 1'b0, 32'h9999_9999, 1'b0);
        wait_rsp("timeout_latency", 9);
        check("timeout_flag", rsp_timeout, 1);
        check("timeout_slverr", rsp_slverr, 1);
        check("timeout_rdata", rsp_rdata, 32'h0);
        wait_idle("timeout_drain");

        // Back-pressure on responses fills the FIFO.
        rsp_ready = 1'b0;
        base = rsp_idx;
        push(1'b1, 23'h000300, 32'hA0A0_0300, 4'hF, 0, 1'b0, 32'h0, 1'b0);
        push(1'b0, 23'h000304, 32'h0, 4'h0, 2, 1'b0, 32'h0BB0_0304, 1'b0);
        check("full_cmd_ready", cmd_ready, 0);
        push(1'b1, 23'h000308, 32'hC0C0_0308, 4'h5, 0, 1'b1, 32'h0, 1'b0);
        repeat (6) tick();
        check("hold_rsp_valid", rsp_valid, 1);
        check("hold_rsp_idx", rsp_idx, base);
        check("hold_cmd_ready", cmd_ready, 0);
        check("hold_psel", psel, 0);
        rsp_ready = 1'b1;
        wait_idle("backpressure_drain");

        // Reset while a hanging access is in progress with two queued.
        push(1'b0, 23'h000400, 32'h0, 4'h0, 0, 1'b0, 32'h0, 1'b1);
        push(1'b1, 23'h000404, 32'h4444_0404, 4'hF, 0, 1'b0, 32'h0, 1'b0);
        push(1'b1, 23'h000408, 32'h4444_0408, 4'hF, 0, 1'b0, 32'h0, 1'b0);
        check("pre_rst_access", {psel, penable}, 2'b11);
        check("pre_rst_full", cmd_ready, 0);
        reset = 1'b1;
        apb_idx = n_pushed;
        rsp_idx = n_pushed;
        #1;
        check("async_rst_psel", psel, 0);
        check("async_rst_penable", penable, 0);
        tick();
        tick();
        check("rst_mid_busy", busy, 0);
        check("rst_mid_cmd_ready", cmd_ready, 1);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        reset = 1'b0;
        tick();
        push(1'b0, 23'h00040C, 32'h0, 4'h0, 0, 1'b0, 32'h7777_0001, 1'b0);
        wait_rsp("post_rst_latency", 3);
        check("post_rst_rdata", rsp_rdata, 32'h7777_0001);
        wait_idle("post_rst_drain");

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
